// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x64 register file.
// Port A (writeback) always wins; port B (long-latency) results queue in a
// FIFO and drain when A is idle. A per-register busy scoreboard tracks
// reserved destinations whose port-B result has not yet been written.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [4:0]    a_reg,
  input  logic [63:0]   a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [4:0]    b_reg,
  input  logic [63:0]   b_data,
  input  logic          rsv_valid,
  input  logic [4:0]    rsv_reg,
  output logic          RegWrite,
  output logic [4:0]    WriteRegister,
  output logic [63:0]   WriteData,
  output logic [31:0]   busy,
  output logic [CW-1:0] fifo_count,
  output logic          fifo_full
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned RW   = 5;
  localparam int unsigned DW   = 64;
  localparam int unsigned NREG = 32;
  localparam logic [RW-1:0] XZR = 5'd31;

  // FIFO storage and state
  logic [RW-1:0]   fifo_reg  [DEPTH];
  logic [DW-1:0]   fifo_data [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic          grant_a;
  logic          fifo_empty;
  logic          pop;
  logic          push;
  logic [RW-1:0] head_reg;
  logic [DW-1:0] head_data;

  // Status outputs depend on registered count only
  assign fifo_empty = (count == '0);
  assign b_ready    = (count < CW'(DEPTH));
  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_count = count;
  assign busy       = busy_q;

  assign head_reg  = fifo_reg[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  // Grant and FIFO handshake decode; X31 writes are treated as no request
  always_comb begin
    grant_a = a_valid && (a_reg != XZR);
    pop     = !reset && !grant_a && !fifo_empty;
    push    = !reset && b_valid && b_ready;
  end

  // Register-file write port mux; quiet while reset is high
  always_comb begin
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    if (!reset) begin
      if (grant_a) begin
        RegWrite      = 1'b1;
        WriteRegister = a_reg;
        WriteData     = a_data;
      end else if (!fifo_empty) begin
        RegWrite      = (head_reg != XZR);
        WriteRegister = head_reg;
        WriteData     = head_data;
      end
    end
  end

  // Scoreboard next state: clear on popped write, then set so a same-cycle
  // reservation of the same register wins
  always_comb begin
    busy_d = busy_q;
    if (pop && (head_reg != XZR)) begin
      busy_d[head_reg] = 1'b0;
    end
    if (rsv_valid && (rsv_reg != XZR)) begin
      busy_d[rsv_reg] = 1'b1;
    end
    busy_d[NREG-1] = 1'b0;
  end

  // FIFO payload storage; contents need no reset, validity comes from count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= b_reg;
      fifo_data[wr_ptr] <= b_data;
    end
  end

  // Pointers, occupancy and scoreboard state
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
